// File: rtl/rv_alu_arb.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters.
// Captures the ALU result into a response register returned over valid/ready.
module rv_alu_arb #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [32*NUM_REQ-1:0]  req_a_i,
    input  logic [32*NUM_REQ-1:0]  req_b_i,
    input  logic [4*NUM_REQ-1:0]   req_ctrl_i,
    output logic [31:0]            alu_a_o,
    output logic [31:0]            alu_b_o,
    output logic [3:0]             alu_ctrl_o,
    input  logic [31:0]            alu_result_i,
    output logic [NUM_REQ-1:0]     rsp_valid_o,
    input  logic [NUM_REQ-1:0]     rsp_ready_i,
    output logic [31:0]            rsp_result_o,
    output logic                   rsp_err_o
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 4;
    localparam logic [CTRL_W-1:0] CTRL_MAX_LEGAL = 4'b1001;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_result_q, rsp_result_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;

    logic                 grant_vld;
    logic [IDX_W-1:0]     grant_idx;
    logic                 issue_en;
    logic                 accept;
    logic                 ctrl_illegal;
    logic [IDX_W:0]       ptr_inc;

    // First valid requester at or after rr_ptr, with wrap-around
    always_comb begin
        logic [IDX_W:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!grant_vld && req_valid_i[cand[IDX_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
    end

    assign issue_en = (state_q == IDLE) || ((state_q == RESP) && rsp_ready_i[owner_q]);
    assign accept   = grant_vld && issue_en;

    // Winner's fields go to the ALU whenever any grant exists, even if stalled
    always_comb begin
        req_ready_o = '0;
        alu_a_o     = '0;
        alu_b_o     = '0;
        alu_ctrl_o  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant_vld && (grant_idx == IDX_W'(k))) begin
                req_ready_o[k] = issue_en;
                alu_a_o        = req_a_i[k*DATA_W +: DATA_W];
                alu_b_o        = req_b_i[k*DATA_W +: DATA_W];
                alu_ctrl_o     = req_ctrl_i[k*CTRL_W +: CTRL_W];
            end
        end
    end

    assign ctrl_illegal = (alu_ctrl_o > CTRL_MAX_LEGAL);
    assign ptr_inc      = {1'b0, grant_idx} + (IDX_W+1)'(1);

    // Next-state: a new accept wins over completion so back-to-back stays in RESP
    always_comb begin
        state_d      = state_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        if (accept) begin
            state_d      = RESP;
            rsp_valid_d  = '0;
            rsp_valid_d[grant_idx] = 1'b1;
            owner_d      = grant_idx;
            rsp_err_d    = ctrl_illegal;
            rsp_result_d = ctrl_illegal ? '0 : alu_result_i;
            rr_ptr_d     = (ptr_inc == (IDX_W+1)'(NUM_REQ)) ? '0 : ptr_inc[IDX_W-1:0];
        end else if ((state_q == RESP) && rsp_ready_i[owner_q]) begin
            state_d     = IDLE;
            rsp_valid_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
        end else begin
            state_q      <= state_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_err_o    = rsp_err_q;

endmodule
